// File: rtl/pipelined_adder_n.sv
// Segment-pipelined ripple-carry adder: NSEG = WIDTH/SEG register stages with a global valid/ready stall.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module pipelined_adder_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NSEG = WIDTH / SEG;

    if (SEG < 1 || WIDTH < 1 || (WIDTH % SEG) != 0) begin : g_param_chk
        $error("pipelined_adder_n: WIDTH must be a non-zero multiple of SEG");
    end

    // Whole pipeline moves together; it only freezes when a finished result is not taken.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int unsigned RW = WIDTH - k * SEG;   // operand bits still to be added
        localparam int unsigned LO = (k + 1) * SEG;     // sum bits resolved after this stage

        logic          v_d;
        logic          c_d;
        logic          v_q;
        logic          c_q;
        logic [RW-1:0] a_rem;
        logic [RW-1:0] b_rem;
        logic [SEG:0]  slice_add;
        logic [LO-1:0] s_d;
        logic [LO-1:0] s_q;

        if (k == 0) begin : g_head
            assign v_d   = in_valid;
            assign c_d   = cin;
            assign a_rem = a;
            assign b_rem = b;
            assign s_d   = slice_add[SEG-1:0];
        end else begin : g_body
            assign v_d   = g_stg[k-1].v_q;
            assign c_d   = g_stg[k-1].c_q;
            assign a_rem = g_stg[k-1].g_skew.a_hi;
            assign b_rem = g_stg[k-1].g_skew.b_hi;
            assign s_d   = {slice_add[SEG-1:0], g_stg[k-1].s_q};
        end

        assign slice_add = {1'b0, a_rem[SEG-1:0]} + {1'b0, b_rem[SEG-1:0]} + {{SEG{1'b0}}, c_d};

        // Lower sum slices ride along with the carry so the full sum emerges at once.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= slice_add[SEG];
                s_q <= s_d;
            end
        end

        // Upper operand slices are delayed so each one meets its incoming carry.
        if (k < NSEG - 1) begin : g_skew
            logic [RW-SEG-1:0] a_hi;
            logic [RW-SEG-1:0] b_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (adv) begin
                    a_hi <= a_rem[RW-1:SEG];
                    b_hi <= b_rem[RW-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].v_q;
    assign sum       = g_stg[NSEG-1].s_q;
    assign cout      = g_stg[NSEG-1].c_q;

`ifdef ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_d;

    assign ovf_d = g_stg[NSEG-1].a_rem[SEG-1] ^ g_stg[NSEG-1].b_rem[SEG-1]
                 ^ g_stg[NSEG-1].slice_add[SEG-1] ^ g_stg[NSEG-1].slice_add[SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (adv) begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Bench for pipelined_adder_n: an 8/4 lane for directed, stall and reset cases and a 3/1 lane streamed exhaustively.
// Results are compared against an arithmetic model of a+b+cin held in per-lane queues.
module tb_pipelined_adder_n;

    localparam int unsigned WA = 8;
    localparam int unsigned SA = 4;
    localparam int unsigned NA = WA / SA;
    localparam int unsigned WB = 3;
    localparam int unsigned SB = 1;
    localparam int unsigned NB = WB / SB;

    typedef struct { int a; int b; int cin; } vec_t;
    typedef struct { int sum; int cout; int ovf; int cyc; } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic          w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_cin, w8_cout;
    logic [WA-1:0] w8_a, w8_b, w8_sum;
    logic          w3_in_valid, w3_in_ready, w3_out_valid, w3_out_ready, w3_cin, w3_cout;
    logic [WB-1:0] w3_a, w3_b, w3_sum;
`ifdef ADDER_OVF_EN
    logic          w8_ovf, w3_ovf;
`endif

    always #5 clk = ~clk;

    pipelined_adder_n #(.WIDTH(WA), .SEG(SA)) u_w8 (
        .clk(clk), .rst(rst),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .a(w8_a), .b(w8_b), .cin(w8_cin),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready),
        .sum(w8_sum), .cout(w8_cout)
`ifdef ADDER_OVF_EN
        , .ovf(w8_ovf)
`endif
    );

    pipelined_adder_n #(.WIDTH(WB), .SEG(SB)) u_w3 (
        .clk(clk), .rst(rst),
        .in_valid(w3_in_valid), .in_ready(w3_in_ready),
        .a(w3_a), .b(w3_b), .cin(w3_cin),
        .out_valid(w3_out_valid), .out_ready(w3_out_ready),
        .sum(w3_sum), .cout(w3_cout)
`ifdef ADDER_OVF_EN
        , .ovf(w3_ovf)
`endif
    );

    vec_t w8_stim[$];
    vec_t w3_stim[$];
    exp_t w8_exp[$];
    exp_t w3_exp[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit lat_en, stall_chk, gap_en, rnd_ready, rst_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input vec_t v, input int w, input int acc_cyc);
        exp_t e;
        int   total, half, sa, sb, ss;
        half  = 1 << (w - 1);
        total = v.a + v.b + v.cin;
        e.sum  = total % (1 << w);
        e.cout = total / (1 << w);
        sa = (v.a >= half) ? v.a - 2 * half : v.a;
        sb = (v.b >= half) ? v.b - 2 * half : v.b;
        ss = sa + sb + v.cin;
        e.ovf = (ss >= half || ss < -half) ? 1 : 0;
        e.cyc = acc_cyc;
        return e;
    endfunction

    task automatic push8(input int a, input int b, input int cin);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin;
        w8_stim.push_back(v);
    endtask

    task automatic push3(input int a, input int b, input int cin);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin;
        w3_stim.push_back(v);
    endtask

    task automatic drive();
        if (rnd_ready) begin
            w8_out_ready = ($urandom_range(3) != 0);
            w3_out_ready = ($urandom_range(3) != 0);
        end
        w8_in_valid = (w8_stim.size() > 0) && (!gap_en || $urandom_range(3) != 0);
        w3_in_valid = (w3_stim.size() > 0) && (!gap_en || $urandom_range(3) != 0);
        if (w8_stim.size() > 0) begin
            w8_a = WA'(w8_stim[0].a); w8_b = WA'(w8_stim[0].b); w8_cin = 1'(w8_stim[0].cin);
        end
        if (w3_stim.size() > 0) begin
            w3_a = WB'(w3_stim[0].a); w3_b = WB'(w3_stim[0].b); w3_cin = 1'(w3_stim[0].cin);
        end
    endtask

    // One clock: observe at negedge (transfers occur at the following posedge), then drive.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            w8_exp.delete();
            w3_exp.delete();
        end else begin
            if (rst_chk) begin
                check("rst_w8_valid", 32'(w8_out_valid), 0);
                check("rst_w8_sum",   32'(w8_sum), 0);
                check("rst_w8_cout",  32'(w8_cout), 0);
                check("rst_w8_ready", 32'(w8_in_ready), 1);
                check("rst_w3_valid", 32'(w3_out_valid), 0);
                check("rst_w3_sum",   32'(w3_sum), 0);
                check("rst_w3_cout",  32'(w3_cout), 0);
`ifdef ADDER_OVF_EN
                check("rst_w8_ovf",   32'(w8_ovf), 0);
`endif
            end
            if (stall_chk) begin
                check("w8_stall_valid", 32'(w8_out_valid), 1);
                check("w8_stall_ready", 32'(w8_in_ready), 0);
            end
            if (w8_out_valid) begin
                if (w8_exp.size() == 0) begin
                    check("w8_extra", 32'(w8_out_valid), 0);
                end else begin
                    e = w8_exp[0];
                    check("w8_sum", 32'(w8_sum), e.sum);
                    check("w8_cout", 32'(w8_cout), e.cout);
`ifdef ADDER_OVF_EN
                    check("w8_ovf", 32'(w8_ovf), e.ovf);
`endif
                    if (w8_out_ready) begin
                        if (lat_en) check("w8_latency", cyc - e.cyc, NA);
                        void'(w8_exp.pop_front());
                    end
                end
            end
            if (w3_out_valid) begin
                if (w3_exp.size() == 0) begin
                    check("w3_extra", 32'(w3_out_valid), 0);
                end else begin
                    e = w3_exp[0];
                    check("w3_sum", 32'(w3_sum), e.sum);
                    check("w3_cout", 32'(w3_cout), e.cout);
`ifdef ADDER_OVF_EN
                    check("w3_ovf", 32'(w3_ovf), e.ovf);
`endif
                    if (w3_out_ready) begin
                        if (lat_en) check("w3_latency", cyc - e.cyc, NB);
                        void'(w3_exp.pop_front());
                    end
                end
            end
            if (w8_in_valid && w8_in_ready) begin
                w8_exp.push_back(model(w8_stim[0], WA, cyc));
                void'(w8_stim.pop_front());
            end
            if (w3_in_valid && w3_in_ready) begin
                w3_exp.push_back(model(w3_stim[0], WB, cyc));
                void'(w3_stim.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((w8_stim.size() + w8_exp.size() + w3_stim.size() + w3_exp.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_w8", 32'(w8_stim.size() + w8_exp.size()), 0);
        check("drain_w3", 32'(w3_stim.size() + w3_exp.size()), 0);
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1;
        lat_en = 1'b0; stall_chk = 1'b0; gap_en = 1'b0; rnd_ready = 1'b0; rst_chk = 1'b0;
        w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_cin = 1'b0; w8_out_ready = 1'b1;
        w3_in_valid = 1'b0; w3_a = '0; w3_b = '0; w3_cin = 1'b0; w3_out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        rst_chk = 1'b1;
        step();
        rst_chk = 1'b0;

        // Directed vectors, back-to-back, unstalled: latency must be exactly NSEG.
        lat_en = 1'b1;
        push8(8'hFF, 8'h01, 0); push8(8'h12, 8'h34, 1);
        push8(8'h01, 8'h02, 0); push8(8'h10, 8'h20, 0); push8(8'h80, 8'h80, 0); push8(8'hF0, 8'h0F, 1);
        push8(8'h7F, 8'h01, 0); push8(8'h80, 8'h80, 0); push8(8'h05, 8'h03, 0); push8(8'hFF, 8'hFF, 1);
        drive();
        drain(100);
        lat_en = 1'b0;

        // Backpressure: fill, hold three stalled cycles, then release.
        w8_out_ready = 1'b0;
        push8(8'h11, 8'h22, 0); push8(8'hAA, 8'h55, 1); push8(8'h0F, 8'hF1, 0); push8(8'h3C, 8'hC3, 1);
        drive();
        repeat (2) step();
        stall_chk = 1'b1;
        repeat (3) step();
        stall_chk = 1'b0;
        w8_out_ready = 1'b1;
        drain(100);

        // Reset while two results are in flight: neither may ever appear.
        w8_out_ready = 1'b0;
        push8(8'h21, 8'h43, 0); push8(8'h65, 8'h87, 1);
        drive();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rst_chk = 1'b1;
        step();
        rst_chk = 1'b0;
        w8_out_ready = 1'b1;
        repeat (6) step();

        // Random stream with bubbles and random backpressure.
        gap_en = 1'b1; rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++)
            push8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
        drive();
        drain(3000);
        gap_en = 1'b0; rnd_ready = 1'b0;
        w8_out_ready = 1'b1; w3_out_ready = 1'b1;

        // Exhaustive 3-bit lane: unstalled with latency checks, then with random backpressure.
        lat_en = 1'b1;
        for (int i = 0; i < 128; i++) push3(i / 16, (i / 2) % 8, i % 2);
        drive();
        drain(1000);
        lat_en = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 128; i++) push3(i / 16, (i / 2) % 8, i % 2);
        drive();
        drain(3000);
        rnd_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
